// File: rtl/qam_cordic_pkg.sv
// ---------------------------------------------------------------------------
// qam_cordic_pkg
// Shared definitions for the QAM-16 CORDIC controllers and datapath:
//   - FSM state encoding (IDLE, LOAD, ITER, GAIN, DONE)
//   - default iteration counter width and iteration count
//   - quadrant codes for the pre-rotation mux
//   - polarity of the sigma (rotation direction) signal
// ---------------------------------------------------------------------------
package qam_cordic_pkg;

  localparam int CORDIC_COUNT_WIDTH = 4;
  localparam int CORDIC_ITERATIONS  = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_GAIN = 3'd3,
    ST_DONE = 3'd4
  } cordic_state_e;

  // Quadrant codes (top two bits of the job angle)
  localparam logic [1:0] QUAD_Q0 = 2'b00;
  localparam logic [1:0] QUAD_Q1 = 2'b01;
  localparam logic [1:0] QUAD_Q2 = 2'b10;
  localparam logic [1:0] QUAD_Q3 = 2'b11;

  // Value of sigma that requests a counter-clockwise micro-rotation
  localparam logic SIGMA_CCW = 1'b1;

endpackage

// File: rtl/cordic_iter_counter.sv
// ---------------------------------------------------------------------------
// cordic_iter_counter
// Iteration counter for the CORDIC controllers. Counts 0..ITERATIONS-1 while
// enabled, returns to 0 after the terminal value and never wraps past it.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (wins over ce)
//   ce     in   clock enable; counter holds when low
//   clr    in   synchronous clear (qualified by ce)
//   en     in   count enable (qualified by ce)
//   count  out  registered iteration index
//   tc     out  terminal count: en high and count == ITERATIONS-1
// ---------------------------------------------------------------------------
module cordic_iter_counter
  import qam_cordic_pkg::*;
#(
  parameter int COUNT_WIDTH = CORDIC_COUNT_WIDTH,
  parameter int ITERATIONS  = CORDIC_ITERATIONS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   clr,
  input  logic                   en,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   tc
);

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(ITERATIONS - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  // Terminal-count decode from the registered count
  always_comb begin
    if (en && (count == CNT_LAST)) begin
      tc = 1'b1;
    end else begin
      tc = 1'b0;
    end
  end

  // Counter register: clear has priority, terminal value folds back to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CNT_ZERO;
    end else if (ce) begin
      if (clr || tc) begin
        count <= CNT_ZERO;
      end else if (en) begin
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/rot_cordic_ctrl.sv
// ---------------------------------------------------------------------------
// rot_cordic_ctrl
// Control sequencer for the iterative rotation-mode CORDIC of the QAM-16
// transmitter. Accepts one job per start handshake, walks the datapath
// through LOAD and ITERATIONS micro-rotations, optionally a gain step, and
// presents the result through an out_valid/out_ready handshake.
//
// Build option: define ROT_CORDIC_GAIN_COMP_EN to insert a one-cycle GAIN
// state between ITER and DONE (gain_en strobe); otherwise gain_en is 0.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ce             clock enable; all state/outputs hold while low
//   start_valid/start_ready  job input handshake
//   quad           job quadrant, latched into pre_rot on accept
//   z_sign         residual angle sign from the datapath (1 = negative)
//   pre_rot        latched quadrant for the pre-rotation mux
//   load_en        datapath load strobe (LOAD state)
//   mux_ctrl       0 = pre-rotated inputs, 1 = feedback
//   shift_bit      iteration index / shift amount / atan ROM address
//   sigma          rotation direction, 1 = counter-clockwise (ITER only)
//   busy           high whenever not IDLE
//   out_valid/out_ready      result handshake
//   gain_en        gain-compensation strobe (GAIN state)
// ---------------------------------------------------------------------------
module rot_cordic_ctrl
  import qam_cordic_pkg::*;
#(
  parameter int COUNT_WIDTH = CORDIC_COUNT_WIDTH,
  parameter int ITERATIONS  = CORDIC_ITERATIONS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [1:0]             quad,
  input  logic                   z_sign,
  output logic [1:0]             pre_rot,
  output logic                   load_en,
  output logic                   mux_ctrl,
  output logic [COUNT_WIDTH-1:0] shift_bit,
  output logic                   sigma,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   gain_en
);

  cordic_state_e state_r;
  cordic_state_e state_nxt_s;
  logic          accept_s;
  logic          cnt_clr_s;
  logic          cnt_en_s;
  logic          cnt_tc_s;

  // Counter is cleared while loading and runs only during micro-rotations
  always_comb begin
    cnt_clr_s = (state_r == ST_LOAD);
    cnt_en_s  = (state_r == ST_ITER);
  end

  cordic_iter_counter #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .ITERATIONS  (ITERATIONS)
  ) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .count (shift_bit),
    .tc    (cnt_tc_s)
  );

  // Next-state and job-accept decode
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_ITER;
      end
      ST_ITER: begin
        if (cnt_tc_s) begin
`ifdef ROT_CORDIC_GAIN_COMP_EN
          state_nxt_s = ST_GAIN;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_ITER;
        end
      end
      ST_GAIN: begin
        state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        // Result consumed: a waiting job is taken in the same cycle so
        // back-to-back jobs see no idle bubble.
        if (out_ready && start_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_LOAD;
        end else if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered control outputs, all derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pre_rot   <= QUAD_Q0;
      load_en   <= 1'b0;
      mux_ctrl  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      gain_en   <= 1'b0;
    end else if (ce) begin
      state_r   <= state_nxt_s;
      if (accept_s) begin
        pre_rot <= quad;
      end
      load_en   <= (state_nxt_s == ST_LOAD);
      mux_ctrl  <= (state_nxt_s == ST_ITER) || (state_nxt_s == ST_GAIN) ||
                   (state_nxt_s == ST_DONE);
      busy      <= (state_nxt_s != ST_IDLE);
      out_valid <= (state_nxt_s == ST_DONE);
`ifdef ROT_CORDIC_GAIN_COMP_EN
      gain_en   <= (state_nxt_s == ST_GAIN);
`else
      gain_en   <= 1'b0;
`endif
    end
  end

  // Input-side ready: free in IDLE, or in DONE when the result is consumed
  always_comb begin
    case (state_r)
      ST_IDLE: start_ready = 1'b1;
      ST_DONE: start_ready = out_ready;
      default: start_ready = 1'b0;
    endcase
  end

  // Rotate towards zero residual angle; direction only meaningful in ITER
  always_comb begin
    if (state_r == ST_ITER) begin
      sigma = (z_sign == 1'b0) ? SIGMA_CCW : ~SIGMA_CCW;
    end else begin
      sigma = 1'b0;
    end
  end

endmodule

// File: tb/tb_rot_cordic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rot_cordic_ctrl
// Self-checking bench for rot_cordic_ctrl. The reference model tracks a job
// only by its age in enabled cycles since acceptance; every expected output
// follows from that age and the documented latency rules.
// ---------------------------------------------------------------------------
module tb_rot_cordic_ctrl;

  localparam int CW = 4;
  localparam int ITERATIONS = 15;
`ifdef ROT_CORDIC_GAIN_COMP_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int DONE_AGE = ITERATIONS + 2 + G;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [1:0]    quad = 2'b00;
  logic          z_sign = 1'b0;
  logic [1:0]    pre_rot;
  logic          load_en;
  logic          mux_ctrl;
  logic [CW-1:0] shift_bit;
  logic          sigma;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          gain_en;

  rot_cordic_ctrl #(.COUNT_WIDTH(CW), .ITERATIONS(ITERATIONS)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .quad        (quad),
    .z_sign      (z_sign),
    .pre_rot     (pre_rot),
    .load_en     (load_en),
    .mux_ctrl    (mux_ctrl),
    .shift_bit   (shift_bit),
    .sigma       (sigma),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .gain_en     (gain_en)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: active job flag, age since accept, latched quadrant
  bit       m_ok = 1'b0;
  bit       m_act = 1'b0;
  int       m_age = 0;
  logic [1:0] m_pre = 2'b00;

  // Observed values captured at the last tick_check
  logic [CW-1:0] o_sb;
  logic o_ov, o_busy, o_mux, o_load, o_sr, o_gain;
  logic [1:0] o_pre;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_iter();
    return m_act && (m_age >= 2) && (m_age <= ITERATIONS + 1);
  endfunction

  // Sample registered outputs mid-cycle and compare against the model
  task automatic tick_check();
    @(negedge clk);
    o_sb = shift_bit; o_ov = out_valid; o_busy = busy; o_mux = mux_ctrl;
    o_load = load_en; o_sr = start_ready; o_gain = gain_en; o_pre = pre_rot;
    if (m_ok) begin
      chk("load_en",   32'(load_en),   32'(m_act && m_age == 1));
      chk("mux_ctrl",  32'(mux_ctrl),  32'(m_act && m_age >= 2));
      chk("shift_bit", 32'(shift_bit), in_iter() ? 32'(m_age - 2) : 32'd0);
      chk("busy",      32'(busy),      32'(m_act));
      chk("out_valid", 32'(out_valid), 32'(m_act && m_age == DONE_AGE));
      chk("gain_en",   32'(gain_en),   32'((G == 1) && m_act && m_age == ITERATIONS + 2));
      chk("pre_rot",   32'(pre_rot),   32'(m_pre));
    end
  endtask

  // Apply one cycle of inputs, check combinational outputs, advance model
  task automatic drive(input logic r, input logic c, input logic sv,
                       input logic [1:0] q, input logic zs, input logic ordy);
    rst = r; ce = c; start_valid = sv; quad = q; z_sign = zs; out_ready = ordy;
    #1;
    if (m_ok) begin
      chk("start_ready", 32'(start_ready), 32'(!m_act || (m_age == DONE_AGE && ordy)));
      chk("sigma",       32'(sigma),       32'(in_iter() && !zs));
    end
    if (r) begin
      m_act = 1'b0; m_age = 0; m_pre = 2'b00; m_ok = 1'b1;
    end else if (c) begin
      if (!m_act) begin
        if (sv) begin m_act = 1'b1; m_age = 1; m_pre = q; end
      end else if (m_age < DONE_AGE) begin
        m_age++;
      end else if (ordy) begin
        if (sv) begin m_age = 1; m_pre = q; end
        else m_act = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  // Called right after an accepting drive; returns after the tick in which
  // out_valid is first seen (lat = cycles since accept, -1 on timeout).
  task automatic run_to_valid(input int stall_at, input int stall_len,
                              output int lat, output logic first_load, output int gcnt);
    int stalls = 0;
    bit stalled = 1'b0;
    lat = -1; first_load = 1'b0; gcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      tick_check();
      if (n == 1) first_load = o_load;
      if (o_gain) gcnt++;
      if (o_ov) begin lat = n; break; end
      if (!stalled && stall_at >= 0 && o_mux && !o_gain && int'(o_sb) == stall_at) begin
        stalled = 1'b1; stalls = stall_len;
      end
      if (stalls > 0) begin
        stalls--;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'($urandom), 1'b0);
      end else begin
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'($urandom), 1'b0);
      end
    end
  endtask

  int lat, gcnt, cnt;
  logic fl;
  bit found;

  initial begin
    // Reset, then a single job with quadrant 2'b10
    tick_check();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick_check();
    chk("rst_ready", 32'(o_sr), 32'd1);
    drive(1'b0, 1'b1, 1'b1, 2'b10, 1'($urandom), 1'b0);
    run_to_valid(-1, 0, lat, fl, gcnt);
    chk("lat_single", 32'(lat), 32'(DONE_AGE));
    chk("first_load", 32'(fl), 32'd1);
    chk("gain_pulses", 32'(gcnt), 32'(G));
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'($urandom), 1'b1);
    tick_check();
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Back-pressure for 5 cycles, then back-to-back accept
    drive(1'b0, 1'b1, 1'b1, 2'b01, 1'($urandom), 1'b0);
    run_to_valid(-1, 0, lat, fl, gcnt);
    chk("lat_job2", 32'(lat), 32'(DONE_AGE));
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 2'b00, 1'($urandom), 1'b0);
      tick_check();
      chk("bp_valid", 32'(o_ov), 32'd1);
      chk("bp_ready", 32'(o_sr), 32'd0);
    end
    drive(1'b0, 1'b1, 1'b1, 2'b11, 1'($urandom), 1'b1);
    run_to_valid(-1, 0, lat, fl, gcnt);
    chk("b2b_load", 32'(fl), 32'd1);
    chk("lat_b2b", 32'(lat), 32'(DONE_AGE));
    chk("b2b_pre", 32'(o_pre), 32'h3);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'($urandom), 1'b1);
    tick_check();

    // ce stall of 3 cycles at shift_bit 7
    drive(1'b0, 1'b1, 1'b1, 2'b00, 1'($urandom), 1'b0);
    run_to_valid(7, 3, lat, fl, gcnt);
    chk("lat_stall", 32'(lat), 32'(DONE_AGE + 3));
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'($urandom), 1'b1);
    tick_check();

    // Mid-job reset at shift_bit 9
    drive(1'b0, 1'b1, 1'b1, 2'b11, 1'($urandom), 1'b0);
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick_check();
      if (o_mux && !o_ov && o_sb == 4'd9) begin found = 1'b1; break; end
      drive(1'b0, 1'b1, 1'b0, 2'b00, 1'($urandom), 1'b0);
    end
    chk("find_sb9", 32'(found), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'($urandom), 1'b0);
    tick_check();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_sb", 32'(o_sb), 32'd0);
    chk("rst_pre", 32'(o_pre), 32'd0);
    cnt = 0;
    for (int n = 0; n < 25; n++) begin
      drive(1'b0, 1'b1, 1'b0, 2'b00, 1'($urandom), 1'($urandom));
      tick_check();
      if (o_ov) cnt++;
    end
    chk("no_valid_after_rst", 32'(cnt), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 2'b01, 1'($urandom), 1'b0);
    run_to_valid(-1, 0, lat, fl, gcnt);
    chk("lat_after_rst", 32'(lat), 32'(DONE_AGE));
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'($urandom), 1'b1);
    tick_check();

    // Randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 8),
            1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 6));
      tick_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rot_cordic_ctrl.md
Name: rot_cordic_ctrl

Overview:
Control sequencer for the iterative rotation-mode CORDIC in the QAM-16 transmitter. It is the mirror of the receiver's vectoring-mode controller. It accepts one phase-rotation job per handshake and drives the datapath's load mux, shift amount/atan ROM address, rotation direction and quadrant pre-rotation. It signals completion through a valid/ready output handshake.

Parameters:
COUNT_WIDTH, 4, width of iteration counter and shift_bit
ITERATIONS, 15, micro-rotations per job; legal range 2..2**COUNT_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
ce  input  1  clock enable; when low, all state and outputs hold
start_valid  input  1  new rotation job available
start_ready  output  1  controller can accept a job this cycle
quad  input  2  angle quadrant of the job (top two angle bits), sampled on accept
z_sign  input  1  sign of datapath residual angle (1 = negative)
pre_rot  output  2  latched quadrant driven to datapath pre-rotation mux
load_en  output  1  datapath register load strobe (LOAD state)
mux_ctrl  output  1  0 = datapath selects pre-rotated inputs, 1 = feedback
shift_bit  output  COUNT_WIDTH  current iteration index = shift amount = atan ROM address
sigma  output  1  rotation direction for this iteration, 1 = counter-clockwise
busy  output  1  high in any state other than IDLE
out_valid  output  1  result in datapath registers is valid
out_ready  input  1  downstream consumes result
gain_en  output  1  gain-compensation strobe (see Optional Feature)

Behaviour:
- A handshake or state transition takes effect only on a cycle with ce=1. All outputs are registered or decoded from registered state.
- Reset (rst=1 at a clk edge, regardless of ce): state=IDLE, counter=0, shift_bit=0, pre_rot=0, load_en=0, mux_ctrl=0, sigma=0, busy=0, out_valid=0, gain_en=0, start_ready=1 after reset. Reset mid-job abandons the job; no out_valid follows.
- IDLE: start_ready=1. If start_valid, latch quad into pre_rot and go to LOAD.
- LOAD (1 cycle): load_en=1, mux_ctrl=0, counter cleared to 0. Next state is ITER.
- ITER: mux_ctrl=1, shift_bit=counter, sigma=~z_sign (combinational from z_sign, valid only in ITER, 0 otherwise). The counter increments per ce cycle. When counter==ITERATIONS-1, the next state is DONE (or GAIN if the feature is enabled) and the counter returns to 0. The counter never wraps past ITERATIONS-1.
- DONE: out_valid=1, mux_ctrl=1, datapath frozen (load_en=0). out_valid holds until out_ready.
  - out_ready=1 and start_valid=0: go to IDLE.
  - out_ready=1 and start_valid=1: accept the new job the same cycle and go directly to LOAD (back-to-back, no idle bubble).
  - start_ready = out_ready in DONE, 0 in LOAD/ITER/GAIN.
- A start_valid asserted while busy and not in DONE with out_ready is ignored. The job is not queued.
- Latency with ce constantly high: job accepted at edge T, out_valid high from cycle T+2+ITERATIONS. This is 17 cycles for the default, 18 with the feature. Throughput is one job per ITERATIONS+2 cycles.
- The ce=0 stall in any state freezes the counter, state and all outputs; the cycle count resumes unchanged.

Optional Feature:
ROT_CORDIC_GAIN_COMP_EN
- Defined: adds a GAIN state between ITER and DONE. For exactly one ce cycle, gain_en=1, mux_ctrl=1 and out_valid=0, so the datapath can scale by K≈0.6073. Latency increases by 1.
- Undefined: no GAIN state; gain_en is tied to 0.

Decomposition:
- Shared package qam_cordic_pkg holds:
  - the state encoding (IDLE, LOAD, ITER, GAIN, DONE)
  - default COUNT_WIDTH and ITERATIONS
  - the quadrant code constants (Q0..Q3)
  - the sigma polarity constant
- The transmitter datapath reuses the package.
- One natural sub-module is cordic_iter_counter: a clear/enable/terminal-count counter reused by the vectoring controller refactor.

Test Plan:
- Reset then single job: rst 1 cycle, start_valid=1, quad=2'b10 at T -> pre_rot=2'b10 and load_en=1 at T+1; shift_bit 0..14 during T+2..T+16; out_valid=1 at T+17; out_ready=1 returns to IDLE with busy=0.
- Direction tracking: toggle z_sign each ITER cycle -> sigma equals ~z_sign each cycle; sigma=0 in IDLE/LOAD/DONE.
- Output back-pressure plus back-to-back: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and start_ready=0. Then assert out_ready=1 and start_valid=1 together -> the next cycle is LOAD with the new quad; no IDLE cycle.
- ce stall: drop ce for 3 cycles when shift_bit=7 -> shift_bit stays 7 and out_valid is delayed by exactly 3 cycles.
- Mid-job reset: assert rst when shift_bit=9 -> next cycle all outputs are at reset values, out_valid never rises, and a new job then completes normally in 17 cycles.
- Feature build (ROT_CORDIC_GAIN_COMP_EN defined) -> gain_en pulses exactly 1 cycle at T+17 and out_valid rises at T+18. Non-feature build -> gain_en is 0 throughout.
